// File: rtl/modulo_varredura_matriz.sv
// Row-scan driver for a 5x7 LED matrix: latches the character select once per
// frame, addresses the preset bank row by row and drives active-low rows with blanking.
module modulo_varredura_matriz #(
    parameter int DIV   = 4,
    parameter int BLANK = 1,
    parameter int NLIN  = 7
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic [1:0]      HH,
    output logic [1:0]      hh_lat,
    output logic [2:0]      linha_idx,
    input  logic [4:0]      cl_in,
    output logic [NLIN-1:0] linhas,
    output logic [4:0]      colunas,
    output logic            fim_quadro
);

    localparam int CMAX = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0]   DIV_FIM   = CW'(DIV - 1);
    localparam logic [CW-1:0]   BLANK_FIM = CW'(BLANK - 1);
    localparam logic [2:0]      ULTIMA    = 3'(NLIN - 1);
    localparam logic [NLIN-1:0] TODAS_OFF = '1;

    typedef enum logic [1:0] {
        OCIOSO,
        ENDERECA,
        EXIBE,
        APAGA
    } estado_t;

    estado_t        estado;
    logic [CW-1:0]  cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado     <= OCIOSO;
            cnt        <= '0;
            hh_lat     <= 2'b00;
            linha_idx  <= 3'd0;
            linhas     <= TODAS_OFF;
            colunas    <= 5'd0;
            fim_quadro <= 1'b0;
        end else begin
            fim_quadro <= 1'b0;
            case (estado)
                OCIOSO: begin
                    linhas  <= TODAS_OFF;
                    colunas <= 5'd0;
                    cnt     <= '0;
                    if (en) begin
                        estado    <= ENDERECA;
                        linha_idx <= 3'd0;
                        hh_lat    <= HH;
                    end
                end

                // cl_in has had a full cycle to settle on (hh_lat, linha_idx)
                ENDERECA: begin
                    colunas <= cl_in;
                    linhas  <= ~(NLIN'(1) << linha_idx);
                    cnt     <= '0;
                    estado  <= EXIBE;
                end

                EXIBE: begin
                    if (cnt == DIV_FIM) begin
                        linhas  <= TODAS_OFF;
                        colunas <= 5'd0;
                        cnt     <= '0;
                        estado  <= APAGA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                APAGA: begin
                    if (cnt == BLANK_FIM) begin
                        cnt <= '0;
                        if (linha_idx < ULTIMA) begin
                            linha_idx <= linha_idx + 3'd1;
                            estado    <= ENDERECA;
                        end else begin
                            // Frame boundary: the only point besides OCIOSO where en and HH matter
                            fim_quadro <= 1'b1;
                            linha_idx  <= 3'd0;
                            if (en) begin
                                hh_lat <= HH;
                                estado <= ENDERECA;
                            end else begin
                                estado <= OCIOSO;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    estado  <= OCIOSO;
                    linhas  <= TODAS_OFF;
                    colunas <= 5'd0;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_modulo_varredura_matriz.sv
// Bench for modulo_varredura_matriz: frame-position model plus directed scenarios.
module tb_modulo_varredura_matriz;

    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int NLIN  = 7;
    localparam int P     = 1 + DIV + BLANK;
    localparam int F     = NLIN * P;

    logic        clk = 0;
    logic        reset_n = 0;
    logic        en = 0;
    logic [1:0]  hh = 2'b00;
    logic [1:0]  hh_lat;
    logic [2:0]  linha_idx;
    logic [4:0]  cl_in;
    logic [6:0]  linhas;
    logic [4:0]  colunas;
    logic        fim_quadro;

    int checks = 0;
    int failures = 0;
    bit chk_on = 0;

    modulo_varredura_matriz #(.DIV(DIV), .BLANK(BLANK), .NLIN(NLIN)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .HH(hh), .hh_lat(hh_lat),
        .linha_idx(linha_idx), .cl_in(cl_in), .linhas(linhas),
        .colunas(colunas), .fim_quadro(fim_quadro)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] cl_tab(input logic [1:0] h, input logic [2:0] r);
        logic [4:0] v;
        v = 5'(int'(r) * 5 + int'(h) * 3 + 1);
        return v ^ {h, 3'b000};
    endfunction

    // Preset bank stand-in
    always_comb cl_in = cl_tab(hh_lat, linha_idx);

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Model: where in the frame are we, counted in cycles since the first ENDERECA
    bit         m_run = 0;
    int         m_t = 0;
    logic [1:0] m_hh = 2'b00;
    bit         m_fim = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_run = 0; m_t = 0; m_hh = 2'b00; m_fim = 0;
        end else begin
            m_fim = 0;
            if (!m_run) begin
                if (en) begin
                    m_run = 1; m_t = 0; m_hh = hh;
                end
            end else begin
                m_t++;
                if (m_t == F) begin
                    m_fim = 1; m_t = 0;
                    if (en) m_hh = hh;
                    else m_run = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && chk_on) begin
            int row, off, e_idx, e_lin, e_col;
            row = m_t / P;
            off = m_t % P;
            e_idx = 0; e_lin = 7'h7f; e_col = 0;
            if (m_run) begin
                e_idx = row;
                if (off >= 1 && off <= DIV) begin
                    e_lin = int'(~(7'b1 << row) & 7'h7f);
                    e_col = int'(cl_tab(m_hh, 3'(row)));
                end
            end
            chk("model_linhas", 32'(linhas), e_lin);
            chk("model_colunas", 32'(colunas), e_col);
            chk("model_linha_idx", 32'(linha_idx), e_idx);
            chk("model_hh_lat", 32'(hh_lat), 32'(m_hh));
            chk("model_fim", 32'(fim_quadro), 32'(m_fim));
            chk("inv_one_low", 32'($countones(~linhas) <= 1), 1);
            chk("inv_col_off", 32'((linhas != 7'h7f) || (colunas == 5'd0)), 1);
            chk("inv_idx_max", 32'(linha_idx <= 3'd6), 1);
        end
    end

    initial begin
        int n, fim_at, low0, nfim;
        bit seen;

        // 1: reset and idle
        reset_n = 0; en = 0; hh = 2'b00;
        repeat (3) tick();
        reset_n = 1;
        chk_on = 1;
        repeat (20) tick();
        chk("idle_linhas", 32'(linhas), 32'h7f);
        chk("idle_colunas", 32'(colunas), 0);
        chk("idle_fim", 32'(fim_quadro), 0);
        chk("idle_idx", 32'(linha_idx), 0);

        // 2: full frame with HH=10
        hh = 2'b10; en = 1;
        fim_at = -1; low0 = 0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (i == 2) begin
                chk("first_row_linhas", 32'(linhas), 32'b1111110);
                chk("first_row_colunas", 32'(colunas), 32'b10111);
            end
            if (i == 8) chk("row1_colunas", 32'(colunas), 32'b11100);
            if (linhas == 7'b1111110 && fim_at < 0) low0++;
            if (fim_quadro && fim_at < 0) fim_at = i;
        end
        chk("frame_fim_edge", fim_at, 43);
        chk("row0_low_cycles", low0, 4);

        // 3: tearing
        hh = 2'b01;
        seen = 0;
        for (n = 0; n < 100 && !seen; n++) begin tick(); seen = fim_quadro; end
        chk("tear_start_fim", 32'(seen), 1);
        chk("tear_start_hh", 32'(hh_lat), 32'b01);
        for (n = 0; n < 100 && linha_idx != 3'd3; n++) tick();
        chk("tear_reach_row3", 32'(linha_idx), 3);
        hh = 2'b11;
        for (n = 0; n < 100 && linha_idx != 3'd6; n++) tick();
        chk("tear_row6_hh", 32'(hh_lat), 32'b01);
        seen = 0;
        for (n = 0; n < 100 && !seen; n++) begin tick(); seen = fim_quadro; end
        chk("tear_next_hh", 32'(hh_lat), 32'b11);
        chk("tear_next_idx", 32'(linha_idx), 0);

        // 4: disable mid-frame
        for (n = 0; n < 100 && !(linha_idx == 3'd2 && linhas != 7'h7f); n++) tick();
        en = 0;
        seen = 0;
        for (n = 0; n < 100 && !seen; n++) begin tick(); seen = fim_quadro; end
        chk("dis_fim_seen", 32'(seen), 1);
        repeat (6) tick();
        chk("dis_linhas", 32'(linhas), 32'h7f);
        chk("dis_colunas", 32'(colunas), 0);
        chk("dis_idx", 32'(linha_idx), 0);

        // 5: async reset during EXIBE of row 4
        en = 1;
        for (n = 0; n < 100 && !(linha_idx == 3'd4 && linhas != 7'h7f); n++) tick();
        chk("rst_reach_row4", 32'(linhas), 32'b1101111);
        #1 reset_n = 0;
        #1;
        chk("rst_linhas", 32'(linhas), 32'h7f);
        chk("rst_colunas", 32'(colunas), 0);
        chk("rst_idx", 32'(linha_idx), 0);
        chk("rst_hh", 32'(hh_lat), 0);
        @(posedge clk);
        #2 reset_n = 1;
        tick();
        tick();
        chk("restart_linhas", 32'(linhas), 32'b1111110);
        chk("restart_idx", 32'(linha_idx), 0);

        // 6: random HH and en
        nfim = 0;
        for (n = 0; n < 3000 && nfim < 10; n++) begin
            hh = 2'($urandom_range(0, 3));
            en = ($urandom_range(0, 3) != 0);
            tick();
            if (fim_quadro) nfim++;
        end
        chk("rand_frames", nfim, 10);

        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/modulo_varredura_matriz.md
Name: modulo_varredura_matriz

Overview:
Row-scan driver for the 5x7 LED matrix. This is the consumer side of the per-row preset modules (modulo_preset_linha_N). The driver latches the character select HH once per frame and presents that latched value plus a row index to the preset bank. It then captures the returned 5-bit column pattern and drives one active-low row at a time, with a blanking gap between rows to suppress ghosting.

Parameters:
DIV, 4, number of clock cycles each row is displayed (EXIBE length), must be >= 1
BLANK, 1, number of all-off clock cycles after each row (APAGA length), must be >= 1
NLIN, 7, number of matrix rows scanned per frame

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
en  input  1  scan enable
HH  input  2  character select from the control logic
hh_lat  output  2  frame-stable HH forwarded to the preset bank
linha_idx  output  3  current row index (0..NLIN-1) forwarded to the preset bank
cl_in  input  5  column pattern returned combinationally by the preset bank for (hh_lat, linha_idx)
linhas  output  NLIN  row drivers, active-low, at most one bit low
colunas  output  5  column drivers, active-high
fim_quadro  output  1  one-cycle pulse when the last row's APAGA completes

Behaviour:
- Reset (async, reset_n=0) clears all state immediately:
  - state=OCIOSO, linhas=all 1, colunas=0, linha_idx=0, hh_lat=0, fim_quadro=0, counter=0.
  - Reset mid-frame aborts the row in progress; no partial pulse follows.
- FSM states are OCIOSO, ENDERECA, EXIBE, APAGA. All outputs are registered.
- OCIOSO:
  - linhas all 1, colunas 0.
  - If en=1, the next cycle is ENDERECA with linha_idx=0, and hh_lat<=HH is latched on that same edge.
- ENDERECA (1 cycle):
  - linhas all 1; linha_idx is stable so cl_in can settle.
  - At the edge leaving this state: colunas<=cl_in, linhas[linha_idx]<=0, counter<=0, go to EXIBE.
- EXIBE (DIV cycles):
  - colunas and linhas are held.
  - When counter==DIV-1: linhas<=all 1, colunas<=0, counter<=0, go to APAGA.
- APAGA (BLANK cycles):
  - When counter==BLANK-1:
    - If linha_idx<NLIN-1: linha_idx++, go to ENDERECA.
    - Else: fim_quadro=1 for exactly that next cycle and linha_idx<=0.
      - If en=1: hh_lat<=HH, go to ENDERECA.
      - If en=0: go to OCIOSO.
- Timing:
  - Row period is 1+DIV+BLANK cycles; frame period is NLIN*(1+DIV+BLANK) cycles.
  - First row goes low 2 cycles after en rises in OCIOSO.
- HH handling: HH changes mid-frame have no effect until the next frame start, so there is no tearing. cl_in is sampled only at ENDERECA exit.
- en deasserted mid-frame: the current frame completes, including fim_quadro, then the FSM returns to OCIOSO. en is sampled only in OCIOSO and at frame end.
- Invariants:
  - Never more than one linhas bit low.
  - colunas is 0 whenever linhas is all 1.
  - linha_idx never exceeds NLIN-1.

Test Plan:
1. Reset with DIV=4, BLANK=1: hold reset_n=0, then release with en=0 -> linhas=7'b1111111, colunas=0, fim_quadro=0, state stays OCIOSO indefinitely.
2. Full frame with DIV=4, BLANK=1: raise en with HH=2'b10, and a bench model returns cl_in as a per-row table -> each row goes low for exactly 4 cycles in order 0..6, followed by 1 all-off cycle. colunas equals the table entry for each row, fim_quadro pulses once, and the frame lasts 42 cycles.
3. Tearing: change HH from 2'b01 to 2'b11 during row 3 -> hh_lat stays 01 through row 6 and becomes 11 on the edge starting the next frame's row 0.
4. Disable mid-frame: drop en during row 2 -> rows 2..6 still complete, fim_quadro pulses, and the FSM then sits in OCIOSO with all rows off.
5. Async reset mid-EXIBE of row 4: assert reset_n=0 asynchronously between clock edges -> linhas all 1 and colunas 0 immediately. After release with en=1, the scan restarts at row 0.
6. Invariant checker over 10 random frames with random HH and en toggling: at most one linhas bit is low, colunas=0 whenever all rows are off, and linha_idx <= 6 at all times.
